// File: rtl/bcd_countdown_59_0.sv
// bcd_countdown_59_0
//   Loadable two-digit BCD countdown timer, 59 down to 00. An internal
//   prescaler produces one decrement every TICK_DIV clocks while running.
//   A small FSM handles load, start, pause and expiry. The count stops at 00;
//   it never wraps back to 59.
//
// Parameters
//   TICK_DIV  clk cycles per decrement (>= 2)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   load      in   1-cycle strobe, captures load_q1/load_q0 (clamped to 5/9)
//   load_q1   in   [3:0] tens digit to load
//   load_q0   in   [3:0] units digit to load
//   start     in   1-cycle strobe, starts counting from the current value
//   pause     in   level, freezes counting while high
//   q1        out  [3:0] tens digit, 0-5
//   q0        out  [3:0] units digit, 0-9
//   running   out  high in RUN only
//   zero      out  combinational, count is 00
//   done      out  1-cycle pulse when the count reaches 00 by decrement
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | stopped, waiting for start (start ignored while count is 00)
// RUN   | prescaler counting, digits decrement on each tick
// PAUSE | prescaler and digits frozen while pause is high
// DONE  | single-cycle expiry state, drives done, then back to IDLE

module bcd_countdown_59_0 #(
   parameter int TICK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_q1,
   input  logic [3:0] load_q0,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] q1,
   output logic [3:0] q0,
   output logic       running,
   output logic       zero,
   output logic       done
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state;
   logic [PW-1:0] prescaler;
   logic          tick;
   logic          last_step;
   logic [3:0]    load_q1_clamped;
   logic [3:0]    load_q0_clamped;

   assign zero            = (q1 == 4'd0) && (q0 == 4'd0);
   assign tick            = (prescaler == TICK_LAST);
   // the only decrement that lands on 00 is 01 -> 00; a borrow always leaves q0 = 9
   assign last_step       = (q1 == 4'd0) && (q0 == 4'd1);
   assign load_q1_clamped = (load_q1 > 4'd5) ? 4'd5 : load_q1;
   assign load_q0_clamped = (load_q0 > 4'd9) ? 4'd9 : load_q0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         prescaler <= '0;
         q1        <= 4'd0;
         q0        <= 4'd0;
         running   <= 1'b0;
         done      <= 1'b0;
      end else if (load) begin
         // load aborts any countdown and swallows a coincident tick or start
         state     <= S_IDLE;
         prescaler <= '0;
         q1        <= load_q1_clamped;
         q0        <= load_q0_clamped;
         running   <= 1'b0;
         done      <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start && !zero) begin
                  state     <= S_RUN;
                  prescaler <= '0;
                  running   <= 1'b1;
               end
            end
            S_RUN: begin
               if (pause) begin
                  state   <= S_PAUSE;
                  running <= 1'b0;
               end else if (tick) begin
                  prescaler <= '0;
                  if (q0 != 4'd0) begin
                     q0 <= q0 - 4'd1;
                  end else if (q1 != 4'd0) begin
                     q0 <= 4'd9;
                     q1 <= q1 - 4'd1;
                  end
                  if (last_step) begin
                     state   <= S_DONE;
                     running <= 1'b0;
                     done    <= 1'b1;
                  end
               end else begin
                  prescaler <= prescaler + PW'(1);
               end
            end
            S_PAUSE: begin
               if (!pause) begin
                  state   <= S_RUN;
                  running <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state   <= S_IDLE;
               running <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_countdown_59_0.sv
// tb_bcd_countdown_59_0
//   Directed scenarios followed by random stimulus, every cycle compared
//   against a reference model that keeps the count as a plain integer
//   number of seconds (0-59) and a cycle count toward the next decrement.

module tb_bcd_countdown_59_0;

   localparam int DIV = 4;

   logic       clk;
   logic       reset;
   logic       load;
   logic [3:0] load_q1;
   logic [3:0] load_q0;
   logic       start;
   logic       pause;
   logic [3:0] q1;
   logic [3:0] q0;
   logic       running;
   logic       zero;
   logic       done;

   int n_cmp;
   int n_err;

   // reference model: mode 0 idle, 1 counting, 2 paused, 3 expired
   int m_secs;
   int m_mode;
   int m_elapsed;

   bcd_countdown_59_0 #(.TICK_DIV(DIV)) dut (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .load_q1 (load_q1),
      .load_q0 (load_q0),
      .start   (start),
      .pause   (pause),
      .q1      (q1),
      .q0      (q0),
      .running (running),
      .zero    (zero),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic rs, input logic ld, input int a,
                             input int b, input logic st, input logic pa);
      if (rs) begin
         m_secs = 0; m_mode = 0; m_elapsed = 0;
      end else if (ld) begin
         m_secs    = 10 * ((a > 5) ? 5 : a) + ((b > 9) ? 9 : b);
         m_mode    = 0;
         m_elapsed = 0;
      end else begin
         case (m_mode)
            0: if (st && m_secs > 0) begin m_mode = 1; m_elapsed = 0; end
            1: begin
               if (pa) m_mode = 2;
               else begin
                  m_elapsed++;
                  if (m_elapsed == DIV) begin
                     m_elapsed = 0;
                     m_secs--;
                     if (m_secs == 0) m_mode = 3;
                  end
               end
            end
            2: if (!pa) m_mode = 1;
            default: m_mode = 0;
         endcase
      end
   endtask

   task automatic check_all();
      chk("q1", int'(q1), m_secs / 10);
      chk("q0", int'(q0), m_secs % 10);
      chk("running", int'(running), (m_mode == 1) ? 1 : 0);
      chk("done", int'(done), (m_mode == 3) ? 1 : 0);
      chk("zero", int'(zero), (m_secs == 0) ? 1 : 0);
   endtask

   task automatic step(input logic rs, input logic ld, input logic [3:0] a,
                       input logic [3:0] b, input logic st, input logic pa);
      reset = rs; load = ld; load_q1 = a; load_q0 = b; start = st; pause = pa;
      @(posedge clk);
      model_step(rs, ld, int'(a), int'(b), st, pa);
      #1;
      check_all();
   endtask

   task automatic idle_cycles(input int n, input logic pa);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, pa);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      m_secs = 0; m_mode = 0; m_elapsed = 0;
      reset = 1'b1; load = 1'b0; load_q1 = 4'd0; load_q0 = 4'd0;
      start = 1'b0; pause = 1'b0;

      // 1: reset, then start on 00 is ignored
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      chk("rst_zero", int'(zero), 1);
      chk("rst_q", int'({q1, q0}), 0);
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
      chk("start_on_zero", int'(running), 0);

      // 2: 03 counts to 00 with a done pulse
      step(1'b0, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
      idle_cycles(3, 1'b0);
      chk("first_tick_not_yet", int'(q0), 3);
      idle_cycles(1, 1'b0);
      chk("first_tick", int'(q0), 2);
      idle_cycles(8, 1'b0);
      chk("done_at_00", int'(done), 1);
      chk("done_q0", int'(q0), 0);
      idle_cycles(1, 1'b0);
      chk("done_one_cycle", int'(done), 0);
      idle_cycles(3, 1'b0);

      // 3: borrow 10 -> 09
      step(1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
      idle_cycles(4, 1'b0);
      chk("borrow", int'({q1, q0}), 8'h09);
      chk("borrow_running", int'(running), 1);

      // 4: clamp 7/12 -> 59, pause mid-count
      step(1'b0, 1'b1, 4'd7, 4'd12, 1'b0, 1'b0);
      chk("clamp", int'({q1, q0}), 8'h59);
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
      idle_cycles(2, 1'b0);
      idle_cycles(10, 1'b1);
      chk("paused_hold", int'({q1, q0}), 8'h59);
      idle_cycles(2, 1'b0);
      chk("resume_pre_tick", int'({q1, q0}), 8'h59);
      idle_cycles(1, 1'b0);
      chk("resume_tick", int'({q1, q0}), 8'h58);

      // 5: load on a tick cycle wins
      step(1'b0, 1'b1, 4'd0, 4'd6, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
      idle_cycles(7, 1'b0);
      chk("at_05", int'({q1, q0}), 8'h05);
      step(1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 1'b0);
      chk("load_over_tick", int'({q1, q0}), 8'h20);
      chk("load_over_tick_run", int'(running), 0);

      // 6: reset during RUN
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
      idle_cycles(5, 1'b0);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      chk("rst_run_q", int'({q1, q0}), 0);
      idle_cycles(6, 1'b0);

      // random phase
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 39) == 0),
              4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 9) < 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
